// File: rtl/i2s_master_ctrl_pkg.sv
// Shared definitions for the I2S bus-master sequencer: FSM encoding and
// the number of flush sck cycles emitted after the last frame.
package i2s_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

    // Full sck cycles generated after the final frame so the receiver can
    // shift out its last right-channel word before sck parks low.
    localparam int unsigned TAIL_CYCLES = 2;

endpackage

// File: rtl/i2s_sck_div.sv
// sck generator: div_cnt counts 0..div_i, and on reaching div_i sck toggles
// and the counter reloads. rise_o/fall_o are high in the aclk cycle whose
// closing edge performs the corresponding toggle. With run_i low the
// counter and sck are parked at 0.
module i2s_sck_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sck_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 sck_q, sck_d;
    logic                 toggle;

    // Next-state for the divider and toggle strobes.
    always_comb begin
        toggle    = run_i && (div_cnt_q == div_i);
        rise_o    = toggle && !sck_q;
        fall_o    = toggle && sck_q;
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        sck_d     = sck_q;
        if (!run_i) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (toggle) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
        end
    end

    // Divider registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S bus-master sequencer. Produces sck/ws from M_AXIS_ACLK with a divider
// and slot length latched at start, counts completed frames, and on stop
// finishes the current stereo frame followed by a short flush tail.
// state_dbg exposes the FSM state for observation.
module i2s_master_ctrl
    import i2s_master_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH  = 8,
    parameter int SLOT_MAX   = 32,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                           M_AXIS_ACLK,
    input  logic                           M_AXIS_ARESETN,
    input  logic                           enable,
    input  logic [DIV_WIDTH-1:0]           div,
    input  logic [$clog2(SLOT_MAX+1)-1:0]  slot_bits,
    output logic                           sck,
    output logic                           ws,
    output logic                           running,
    output logic                           frame_start,
    output logic [FCNT_WIDTH-1:0]          frame_count,
    output logic [1:0]                     state_dbg
);

    localparam int SW = $clog2(SLOT_MAX + 1);
    localparam int BW = $clog2(2 * SLOT_MAX);

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_l_q, div_l_d;
    logic [SW-1:0]         slot_l_q, slot_l_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            tail_cnt_q, tail_cnt_d;
    logic                  ws_q, ws_d;
    logic                  frame_start_q, frame_start_d;
    logic [FCNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic                  sck_rise, sck_fall;
    logic [BW-1:0]         half_last, frame_last;
    logic [DIV_WIDTH-1:0]  div_clamped;
    logic [SW-1:0]         slot_clamped;

    i2s_sck_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sck_div (
        .clk_i  (M_AXIS_ACLK),
        .rst_ni (M_AXIS_ARESETN),
        .run_i  (state_q != ST_IDLE),
        .div_i  (div_l_q),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Config clamping and bit-counter limits derived from the latched slot.
    always_comb begin
        div_clamped  = (div == '0) ? DIV_WIDTH'(1) : div;
        slot_clamped = slot_bits;
        if (slot_bits < SW'(2)) begin
            slot_clamped = SW'(2);
        end else if (slot_bits > SW'(SLOT_MAX)) begin
            slot_clamped = SW'(SLOT_MAX);
        end
        // bit_cnt value on the last bit of the left slot / of the frame.
        half_last  = BW'(slot_l_q) - BW'(1);
        frame_last = BW'({slot_l_q, 1'b0}) - BW'(1);
    end

    // FSM next-state, bit counter, ws and frame statistics.
    always_comb begin
        state_d       = state_q;
        div_l_d       = div_l_q;
        slot_l_d      = slot_l_q;
        bit_cnt_d     = bit_cnt_q;
        tail_cnt_d    = tail_cnt_q;
        ws_d          = ws_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                ws_d       = 1'b0;
                bit_cnt_d  = '0;
                tail_cnt_d = '0;
                if (enable) begin
                    div_l_d       = div_clamped;
                    slot_l_d      = slot_clamped;
                    state_d       = ST_RUN;
                    frame_start_d = 1'b1;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (state_q == ST_RUN && !enable) begin
                    state_d = ST_DRAIN;
                end
                if (sck_fall) begin
                    if (bit_cnt_q == frame_last) begin
                        bit_cnt_d     = '0;
                        ws_d          = 1'b0;
                        frame_count_d = frame_count_q + FCNT_WIDTH'(1);
                        if (state_q == ST_RUN && enable) begin
                            frame_start_d = 1'b1;
                        end else begin
                            // Stop requested: this wrap closes the last frame.
                            state_d    = ST_TAIL;
                            tail_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == half_last) begin
                            ws_d = 1'b1;
                        end
                    end
                end
            end

            ST_TAIL: begin
                ws_d = 1'b0;
                if (sck_fall) begin
                    if (tail_cnt_q == 2'(TAIL_CYCLES - 1)) begin
                        tail_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q       <= ST_IDLE;
            div_l_q       <= '0;
            slot_l_q      <= '0;
            bit_cnt_q     <= '0;
            tail_cnt_q    <= '0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            div_l_q       <= div_l_d;
            slot_l_q      <= slot_l_d;
            bit_cnt_q     <= bit_cnt_d;
            tail_cnt_q    <= tail_cnt_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // sck_rise is part of the divider interface but not needed here.
    logic unused_rise;
    assign unused_rise = sck_rise;

    assign ws          = ws_q;
    assign running     = (state_q != ST_IDLE);
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Directed bench for i2s_master_ctrl. Cycle numbers are counted in rising
// aclk edges from the edge that leaves IDLE (cyc=0); outputs are sampled
// 1 ns after each rising edge.
module tb_i2s_master_ctrl;
    import i2s_master_ctrl_pkg::*;

    localparam int DIV_WIDTH  = 8;
    localparam int SLOT_MAX   = 32;
    localparam int FCNT_WIDTH = 16;
    localparam int SW         = $clog2(SLOT_MAX + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [DIV_WIDTH-1:0]  div = '0;
    logic [SW-1:0]         slot_bits = '0;
    logic                  sck, ws, running, frame_start;
    logic [FCNT_WIDTH-1:0] frame_count;
    logic [1:0]            state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    i2s_master_ctrl #(
        .DIV_WIDTH  (DIV_WIDTH),
        .SLOT_MAX   (SLOT_MAX),
        .FCNT_WIDTH (FCNT_WIDTH)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .enable         (enable),
        .div            (div),
        .slot_bits      (slot_bits),
        .sck            (sck),
        .ws             (ws),
        .running        (running),
        .frame_start    (frame_start),
        .frame_count    (frame_count),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ws", 32'(ws), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_fstart", 32'(frame_start), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();

        // ---------------- div=1, slot=16, enable held ----------------
        rst_n     = 1'b1;
        div       = 8'd1;
        slot_bits = 6'd16;
        enable    = 1'b1;
        tick();
        cyc = 0;
        check("a0_running", 32'(running), 32'd1);
        check("a0_fstart", 32'(frame_start), 32'd1);
        check("a0_sck", 32'(sck), 32'd0);
        step_to(1);
        check("a1_fstart", 32'(frame_start), 32'd0);
        check("a1_sck", 32'(sck), 32'd0);
        step_to(2);
        check("a2_sck_rise", 32'(sck), 32'd1);
        step_to(4);
        check("a4_sck_fall", 32'(sck), 32'd0);
        step_to(63);
        check("a63_ws", 32'(ws), 32'd0);
        step_to(64);
        check("a64_ws", 32'(ws), 32'd1);
        step_to(127);
        check("a127_ws", 32'(ws), 32'd1);
        check("a127_fstart", 32'(frame_start), 32'd0);
        check("a127_fcount", 32'(frame_count), 32'd0);
        step_to(128);
        check("a128_ws", 32'(ws), 32'd0);
        check("a128_fstart", 32'(frame_start), 32'd1);
        check("a128_fcount", 32'(frame_count), 32'd1);
        step_to(129);
        check("a129_fstart", 32'(frame_start), 32'd0);

        // Config changes while running must not disturb timing.
        div       = 8'd3;
        slot_bits = 6'd40;
        step_to(192);
        check("a192_ws", 32'(ws), 32'd1);
        step_to(256);
        check("a256_fstart", 32'(frame_start), 32'd1);
        check("a256_fcount", 32'(frame_count), 32'd2);

        // ---------------- stop at bit_cnt=5 ----------------
        step_to(276);
        enable = 1'b0;
        step_to(277);
        check("s277_state", 32'(state_dbg), 32'(ST_DRAIN));
        check("s277_running", 32'(running), 32'd1);
        step_to(383);
        check("s383_ws", 32'(ws), 32'd1);
        step_to(384);
        check("s384_ws", 32'(ws), 32'd0);
        check("s384_fcount", 32'(frame_count), 32'd3);
        check("s384_fstart", 32'(frame_start), 32'd0);
        check("s384_state", 32'(state_dbg), 32'(ST_TAIL));
        step_to(386);
        check("s386_sck", 32'(sck), 32'd1);
        step_to(388);
        check("s388_sck", 32'(sck), 32'd0);
        step_to(391);
        check("s391_sck", 32'(sck), 32'd1);
        check("s391_ws", 32'(ws), 32'd0);
        check("s391_running", 32'(running), 32'd1);
        step_to(392);
        check("s392_sck", 32'(sck), 32'd0);
        check("s392_running", 32'(running), 32'd0);
        check("s392_state", 32'(state_dbg), 32'(ST_IDLE));
        step_to(395);
        check("s395_sck_parked", 32'(sck), 32'd0);
        check("s395_running", 32'(running), 32'd0);

        // ---------------- restart: div=0, slot=40 (clamped) ----------------
        div    = 8'd0;
        enable = 1'b1;
        tick();
        cyc = 0;
        check("c0_fstart", 32'(frame_start), 32'd1);
        check("c0_fcount", 32'(frame_count), 32'd3);
        step_to(2);
        check("c2_sck_rise", 32'(sck), 32'd1);
        step_to(127);
        check("c127_ws", 32'(ws), 32'd0);
        step_to(128);
        check("c128_ws", 32'(ws), 32'd1);
        step_to(255);
        check("c255_fstart", 32'(frame_start), 32'd0);
        check("c255_ws", 32'(ws), 32'd1);
        step_to(256);
        check("c256_fstart", 32'(frame_start), 32'd1);
        check("c256_ws", 32'(ws), 32'd0);
        check("c256_fcount", 32'(frame_count), 32'd4);

        // ---------------- async reset mid-frame ----------------
        step_to(418);
        check("r418_sck", 32'(sck), 32'd1);
        check("r418_ws", 32'(ws), 32'd1);
        rst_n = 1'b0;
        #2;
        check("r_sck", 32'(sck), 32'd0);
        check("r_ws", 32'(ws), 32'd0);
        check("r_running", 32'(running), 32'd0);
        check("r_fcount", 32'(frame_count), 32'd0);
        check("r_state", 32'(state_dbg), 32'(ST_IDLE));

        // ---------------- 1-cycle pulse, div=2, slot=1 (clamped to 2) ----------------
        rst_n     = 1'b1;
        div       = 8'd2;
        slot_bits = 6'd1;
        enable    = 1'b1;
        tick();
        cyc = 0;
        check("p0_fstart", 32'(frame_start), 32'd1);
        check("p0_running", 32'(running), 32'd1);
        enable = 1'b0;
        step_to(1);
        check("p1_state", 32'(state_dbg), 32'(ST_DRAIN));
        step_to(2);
        check("p2_sck", 32'(sck), 32'd0);
        step_to(3);
        check("p3_sck_rise", 32'(sck), 32'd1);
        step_to(11);
        check("p11_ws", 32'(ws), 32'd0);
        step_to(12);
        check("p12_ws", 32'(ws), 32'd1);
        step_to(23);
        check("p23_ws", 32'(ws), 32'd1);
        check("p23_fcount", 32'(frame_count), 32'd0);
        step_to(24);
        check("p24_ws", 32'(ws), 32'd0);
        check("p24_fcount", 32'(frame_count), 32'd1);
        check("p24_fstart", 32'(frame_start), 32'd0);
        check("p24_state", 32'(state_dbg), 32'(ST_TAIL));
        step_to(28);
        enable = 1'b1;
        step_to(30);
        check("p30_state", 32'(state_dbg), 32'(ST_TAIL));
        step_to(35);
        check("p35_sck", 32'(sck), 32'd1);
        check("p35_running", 32'(running), 32'd1);
        step_to(36);
        check("p36_sck", 32'(sck), 32'd0);
        check("p36_running", 32'(running), 32'd0);
        check("p36_fstart", 32'(frame_start), 32'd0);
        step_to(37);
        check("p37_running", 32'(running), 32'd1);
        check("p37_fstart", 32'(frame_start), 32'd1);
        check("p37_fcount", 32'(frame_count), 32'd1);
        check("p37_state", 32'(state_dbg), 32'(ST_RUN));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
